dam_host_port: RTL and testbench
================================

Name: dam_host_port

Overview:
- Host-side endpoint for the diff/add/mul compute core.
- Accepts operand commands from upstream over a valid/ready interface and buffers them in a command FIFO.
- Drives them onto the core's i/j/k/operation inputs, honouring the core's accept (valid) output.
- Captures the core's add and mul result strobes into a response FIFO and returns them downstream over valid/ready, with credit accounting so no core result is ever dropped.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of 2, >=2)
RSP_DEPTH, 8, response FIFO entries and max in-flight ops (power of 2, >=2)
IDLE_OP, 1, operation bit driven to core when no command is presented

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  upstream command valid
cmd_ready  out  1  command FIFO not full
cmd_i  in  8  operand i
cmd_j  in  8  operand j
cmd_k  in  8  operand k
cmd_op  in  1  0 = add path, 1 = mul path
core_i  out  8  operand i to core
core_j  out  8  operand j to core
core_k  out  8  operand k to core
core_op  out  1  operation to core
core_req  out  1  core_i/j/k/op carry a real command
core_accept  in  1  core input-accept (core's valid output)
add_vld  in  1  core add result strobe, 1 cycle
add_data  in  8  add result (vo1)
mul_vld  in  1  core mul result strobe, 1 cycle
mul_data  in  8  mul result (vo2)
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  downstream ready
rsp_data  out  8  head result
rsp_op  out  1  head result path, 0 = add, 1 = mul
outstanding  out  4  issued ops not yet returned (width log2(RSP_DEPTH)+1)
err_unexp  out  1  sticky, result strobe with outstanding==0

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Reset state:
  - both FIFOs empty, outstanding=0, err_unexp=0.
  - core_req=0; core_i/j/k=0, core_op=IDLE_OP.
  - cmd_ready=1, rsp_valid=0.
  - Reset mid-operation discards all buffered commands and results; results arriving in the reset cycle are ignored.
- Command push: when cmd_valid && cmd_ready. cmd_ready = !cmd_full (registered count; no same-cycle pop-through).
- Core drive (combinational from FIFO head):
  - core_i/j/k/op = head entry when cmd FIFO non-empty and credit is available; otherwise 0/0/0/IDLE_OP.
  - core_req = cmd_nonempty && credit.
- Credit rule: credit = (outstanding + rsp_count) < RSP_DEPTH, using registered values.
- Issue event = core_req && core_accept. On issue: pop cmd FIFO, outstanding += 1.
- Operands stay stable while core_req=1 and core_accept=0 (stall); the head never changes without an issue.
- Result capture:
  - add_vld writes {0, add_data}; mul_vld writes {1, mul_data}.
  - Each accepted strobe decrements outstanding.
  - Both strobes in the same cycle: two writes, add entry first, outstanding -= 2.
  - Simultaneous issue and return: net update (+1 -1 etc.) in one cycle.
- Response pop: on rsp_valid && rsp_ready. rsp_data/rsp_op come from the FIFO head (registered storage, zero-latency head view).
- Response ordering is arrival order, not issue order; add results may overtake earlier mul commands.
- Overflow cannot occur by the credit rule.
- Strobe with outstanding==0 (or outstanding==1 with both strobes):
  - sets err_unexp;
  - the result is still written if space remains, else dropped;
  - outstanding saturates at 0.
- Minimum latency cmd push -> core_req: 1 cycle (FIFO write then head visible).
- Pointers wrap modulo depth. A full cmd FIFO with a simultaneous pop still holds cmd_ready=0 for that cycle.

Test Plan:
- Reset, then push add cmd i=3, j=5, k=2, op=0 with core_accept=1 -> core_req=1 next cycle with core_i=3, core_j=5, core_k=2; outstanding=1. Then add_vld with add_data=0x0A -> rsp_valid=1, rsp_data=0x0A, rsp_op=0, outstanding=0.
- Hold core_accept=0 for 5 cycles with 4 cmds pushed -> cmd_ready=0 after 4th push; core operands remain the first cmd throughout; release -> 4 issues on consecutive cycles in FIFO order.
- rsp_ready=0, issue 8 ops, return 8 results -> after 8 issues core_req=0 despite pending cmd; drain 1 response -> core_req returns to 1 the next cycle.
- Same-cycle add_vld=1 (0x11) and mul_vld=1 (0x22) with outstanding=2 -> two responses, 0x11/op0 then 0x22/op1; outstanding=0; err_unexp=0.
- mul_vld pulse with outstanding=0 -> err_unexp=1 and remains set; outstanding stays 0. rst -> err_unexp=0, rsp_valid=0.
- Assert rst mid-stream with 3 cmds queued and 2 outstanding -> next cycle core_req=0, outstanding=0, cmd_ready=1, core_op=IDLE_OP.

Source files
------------

// File: rtl/dam_host_port_if.sv
// Bundles the command, core and response signals of the host port.
// Handshakes: a transfer happens on a clock edge where valid && ready are both high.
// Payload is held stable while valid is high and ready is low, and valid never drops without a transfer.
interface dam_host_port_if #(
    parameter int OW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_i;
    logic [7:0]    cmd_j;
    logic [7:0]    cmd_k;
    logic          cmd_op;
    logic [7:0]    core_i;
    logic [7:0]    core_j;
    logic [7:0]    core_k;
    logic          core_op;
    logic          core_req;
    logic          core_accept;
    logic          add_vld;
    logic [7:0]    add_data;
    logic          mul_vld;
    logic [7:0]    mul_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_data;
    logic          rsp_op;
    logic [OW-1:0] outstanding;
    logic          err_unexp;

    modport slave (
        input  cmd_valid, cmd_i, cmd_j, cmd_k, cmd_op, core_accept,
               add_vld, add_data, mul_vld, mul_data, rsp_ready,
        output cmd_ready, core_i, core_j, core_k, core_op, core_req,
               rsp_valid, rsp_data, rsp_op, outstanding, err_unexp
    );

    modport master (
        output cmd_valid, cmd_i, cmd_j, cmd_k, cmd_op, core_accept,
               add_vld, add_data, mul_vld, mul_data, rsp_ready,
        input  cmd_ready, core_i, core_j, core_k, core_op, core_req,
               rsp_valid, rsp_data, rsp_op, outstanding, err_unexp
    );
endinterface

// File: rtl/dam_host_port.sv
// Host endpoint for the diff/add/mul core: command FIFO feeding the core and a response FIFO
// fed by the core's result strobes, with credit so every issued op has a response slot.
module dam_host_port #(
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 8,
    parameter bit IDLE_OP   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    dam_host_port_if.slave io
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RSP_DEPTH);
    localparam logic [CAW:0]   L_CMD_DEPTH = CMD_DEPTH;
    localparam logic [RAW:0]   L_RSP_DEPTH = RSP_DEPTH;
    localparam logic [RAW+1:0] L_CREDIT    = RSP_DEPTH;

    logic [24:0]    r_cmd_mem [CMD_DEPTH];
    logic [CAW-1:0] r_cmd_wp;
    logic [CAW-1:0] r_cmd_rp;
    logic [CAW:0]   r_cmd_cnt;
    logic [8:0]     r_rsp_mem [RSP_DEPTH];
    logic [RAW-1:0] r_rsp_wp;
    logic [RAW-1:0] r_rsp_rp;
    logic [RAW:0]   r_rsp_cnt;
    logic [RAW:0]   r_outst;
    logic           r_err;

    logic           w_push;
    logic           w_credit;
    logic           w_core_req;
    logic           w_issue;
    logic [24:0]    w_head;
    logic [8:0]     w_rsp_head;
    logic           w_rsp_pop;
    logic [RAW:0]   w_rsp_space;
    logic           w_add_wr;
    logic           w_mul_wr;
    logic [RAW-1:0] w_mul_addr;
    logic [RAW:0]   w_ndec;
    logic [RAW:0]   w_out_sat;

    assign w_push      = io.cmd_valid && (r_cmd_cnt != L_CMD_DEPTH);
    // Credit counts both in-flight ops and parked results, so returns can never overflow.
    assign w_credit    = ({1'b0, r_outst} + {1'b0, r_rsp_cnt}) < L_CREDIT;
    assign w_core_req  = (r_cmd_cnt != '0) && w_credit;
    assign w_issue     = w_core_req && io.core_accept;
    assign w_head      = r_cmd_mem[r_cmd_rp];

    assign io.cmd_ready = (r_cmd_cnt != L_CMD_DEPTH);
    assign io.core_req  = w_core_req;
    assign io.core_i    = w_core_req ? w_head[7:0]   : 8'd0;
    assign io.core_j    = w_core_req ? w_head[15:8]  : 8'd0;
    assign io.core_k    = w_core_req ? w_head[23:16] : 8'd0;
    assign io.core_op   = w_core_req ? w_head[24]    : IDLE_OP;

    assign w_rsp_head   = r_rsp_mem[r_rsp_rp];
    assign w_rsp_pop    = (r_rsp_cnt != '0) && io.rsp_ready;
    assign w_rsp_space  = L_RSP_DEPTH - r_rsp_cnt;
    assign w_add_wr     = io.add_vld && (w_rsp_space != '0);
    assign w_mul_wr     = io.mul_vld && (w_rsp_space > {{RAW{1'b0}}, w_add_wr});
    assign w_mul_addr   = r_rsp_wp + {{(RAW-1){1'b0}}, w_add_wr};
    assign w_ndec       = {{RAW{1'b0}}, io.add_vld} + {{RAW{1'b0}}, io.mul_vld};
    assign w_out_sat    = (r_outst >= w_ndec) ? (r_outst - w_ndec) : '0;

    assign io.rsp_valid   = (r_rsp_cnt != '0);
    assign io.rsp_data    = w_rsp_head[7:0];
    assign io.rsp_op      = w_rsp_head[8];
    assign io.outstanding = r_outst;
    assign io.err_unexp   = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_wp  <= '0;
            r_cmd_rp  <= '0;
            r_cmd_cnt <= '0;
            r_rsp_wp  <= '0;
            r_rsp_rp  <= '0;
            r_rsp_cnt <= '0;
            r_outst   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_cmd_mem[r_cmd_wp] <= {io.cmd_op, io.cmd_k, io.cmd_j, io.cmd_i};
                r_cmd_wp            <= r_cmd_wp + 1'b1;
            end
            if (w_issue) r_cmd_rp <= r_cmd_rp + 1'b1;
            r_cmd_cnt <= r_cmd_cnt + {{CAW{1'b0}}, w_push} - {{CAW{1'b0}}, w_issue};

            // Add lands ahead of mul when both strobe in the same cycle.
            if (w_add_wr) r_rsp_mem[r_rsp_wp] <= {1'b0, io.add_data};
            if (w_mul_wr) r_rsp_mem[w_mul_addr] <= {1'b1, io.mul_data};
            r_rsp_wp  <= r_rsp_wp + {{(RAW-1){1'b0}}, w_add_wr} + {{(RAW-1){1'b0}}, w_mul_wr};
            if (w_rsp_pop) r_rsp_rp <= r_rsp_rp + 1'b1;
            r_rsp_cnt <= r_rsp_cnt + {{RAW{1'b0}}, w_add_wr} + {{RAW{1'b0}}, w_mul_wr}
                         - {{RAW{1'b0}}, w_rsp_pop};

            r_outst <= w_out_sat + {{RAW{1'b0}}, w_issue};
            if (w_ndec > r_outst) r_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dam_host_port.sv
// Self-checking bench for dam_host_port: directed scenarios plus a randomized run against
// a queue-based reference model and a small core emulator with variable result latency.
module tb_dam_host_port;
    localparam int CMD_DEPTH = 4;
    localparam int RSP_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dam_host_port_if #(.OW(4)) io ();

    dam_host_port #(.CMD_DEPTH(CMD_DEPTH), .RSP_DEPTH(RSP_DEPTH), .IDLE_OP(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    // Reference model: command queue, expected-response queue, in-flight count, sticky error.
    logic [24:0] cmd_q[$];
    logic [8:0]  exp_q[$];
    int          m_outst = 0;
    bit          m_err = 1'b0;
    bit          m_issued = 1'b0;
    bit          m_pushed = 1'b0;
    logic [24:0] m_issued_cmd;

    typedef struct {
        logic       op;
        logic [7:0] data;
        int         due;
    } pend_t;
    pend_t pend_q[$];

    function automatic bit e_ready();
        return cmd_q.size() < CMD_DEPTH;
    endfunction

    function automatic bit e_req();
        return (cmd_q.size() > 0) && ((m_outst + exp_q.size()) < RSP_DEPTH);
    endfunction

    function automatic logic [24:0] e_core();
        return e_req() ? cmd_q[0] : 25'h1000000;
    endfunction

    task automatic model_step();
        bit rdy, req;
        int n, space;
        rdy = e_ready();
        req = e_req();
        m_issued = 1'b0;
        m_pushed = 1'b0;
        if (rst) begin
            cmd_q.delete();
            exp_q.delete();
            m_outst = 0;
            m_err = 1'b0;
            return;
        end
        if (req && io.core_accept) begin
            m_issued = 1'b1;
            m_issued_cmd = cmd_q.pop_front();
        end
        if (io.cmd_valid && rdy) begin
            m_pushed = 1'b1;
            cmd_q.push_back({io.cmd_op, io.cmd_k, io.cmd_j, io.cmd_i});
        end
        n = int'(io.add_vld) + int'(io.mul_vld);
        if (n > m_outst) m_err = 1'b1;
        space = RSP_DEPTH - exp_q.size();
        if (exp_q.size() > 0 && io.rsp_ready) void'(exp_q.pop_front());
        if (io.add_vld && space > 0) begin
            exp_q.push_back({1'b0, io.add_data});
            space--;
        end
        if (io.mul_vld && space > 0) exp_q.push_back({1'b1, io.mul_data});
        m_outst = ((m_outst > n) ? m_outst - n : 0) + int'(m_issued);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        io.cmd_valid = 1'b0;
        io.cmd_i = 8'd0;
        io.cmd_j = 8'd0;
        io.cmd_k = 8'd0;
        io.cmd_op = 1'b0;
        io.core_accept = 1'b0;
        io.add_vld = 1'b0;
        io.add_data = 8'd0;
        io.mul_vld = 1'b0;
        io.mul_data = 8'd0;
        io.rsp_ready = 1'b0;
    endtask

    task automatic set_cmd(input logic [24:0] c);
        io.cmd_valid = 1'b1;
        {io.cmd_op, io.cmd_k, io.cmd_j, io.cmd_i} = c;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (io.cmd_ready !== 1'b1 || io.rsp_valid !== 1'b0 || io.core_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b rsp_valid=%b core_req=%b required 1 0 0",
                     io.cmd_ready, io.rsp_valid, io.core_req);
        end
        checks++;
        if ({io.core_op, io.core_k, io.core_j, io.core_i} !== 25'h1000000) begin
            errors++;
            $display("FAIL reset_core: op/k/j/i=%h required 1000000",
                     {io.core_op, io.core_k, io.core_j, io.core_i});
        end
        checks++;
        if (io.outstanding !== 4'd0 || io.err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt: outstanding=%0d err=%b required 0 0", io.outstanding, io.err_unexp);
        end
    endtask

    task automatic test_basic();
        do_reset();
        io.core_accept = 1'b1;
        set_cmd({1'b0, 8'd2, 8'd5, 8'd3});
        tick();
        io.cmd_valid = 1'b0;
        checks++;
        if (io.core_req !== 1'b1 || io.core_i !== 8'd3 || io.core_j !== 8'd5 || io.core_k !== 8'd2
            || io.core_op !== 1'b0) begin
            errors++;
            $display("FAIL basic_drive: req=%b i=%0d j=%0d k=%0d op=%b required 1 3 5 2 0",
                     io.core_req, io.core_i, io.core_j, io.core_k, io.core_op);
        end
        tick();
        checks++;
        if (io.outstanding !== 4'd1 || io.core_req !== 1'b0) begin
            errors++;
            $display("FAIL basic_issue: outstanding=%0d req=%b required 1 0", io.outstanding, io.core_req);
        end
        io.add_vld = 1'b1;
        io.add_data = 8'h0A;
        tick();
        io.add_vld = 1'b0;
        checks++;
        if (io.rsp_valid !== 1'b1 || io.rsp_data !== 8'h0A || io.rsp_op !== 1'b0 || io.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL basic_rsp: valid=%b data=%h op=%b outstanding=%0d required 1 0a 0 0",
                     io.rsp_valid, io.rsp_data, io.rsp_op, io.outstanding);
        end
        io.rsp_ready = 1'b1;
        tick();
        io.rsp_ready = 1'b0;
        checks++;
        if (io.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: rsp_valid=%b required 0", io.rsp_valid);
        end
    endtask

    task automatic test_stall();
        logic [24:0] c [4];
        do_reset();
        for (int n = 0; n < 4; n++) begin
            c[n] = 25'($urandom);
            set_cmd(c[n]);
            tick();
        end
        io.cmd_valid = 1'b0;
        checks++;
        if (io.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_full: cmd_ready=%b required 0", io.cmd_ready);
        end
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (io.core_req !== 1'b1 || {io.core_op, io.core_k, io.core_j, io.core_i} !== c[0]) begin
                errors++;
                $display("FAIL stall_hold: cyc=%0d req=%b cmd=%h required 1 %h", n, io.core_req,
                         {io.core_op, io.core_k, io.core_j, io.core_i}, c[0]);
            end
            tick();
        end
        io.core_accept = 1'b1;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (io.core_req !== 1'b1 || {io.core_op, io.core_k, io.core_j, io.core_i} !== c[n]) begin
                errors++;
                $display("FAIL stall_release: n=%0d req=%b cmd=%h required 1 %h", n, io.core_req,
                         {io.core_op, io.core_k, io.core_j, io.core_i}, c[n]);
            end
            tick();
        end
        io.core_accept = 1'b0;
        checks++;
        if (io.outstanding !== 4'd4 || io.cmd_ready !== 1'b1 || io.core_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_after: outstanding=%0d ready=%b req=%b required 4 1 0",
                     io.outstanding, io.cmd_ready, io.core_req);
        end
    endtask

    task automatic test_credit();
        int pushed = 0;
        int budget = 0;
        do_reset();
        io.core_accept = 1'b1;
        while (exp_q.size() < RSP_DEPTH && budget < 100) begin
            if (pushed < 9) set_cmd(25'($urandom));
            else io.cmd_valid = 1'b0;
            io.add_vld = (m_outst > 0);
            io.add_data = 8'($urandom);
            tick();
            if (m_pushed) pushed++;
            budget++;
        end
        io.cmd_valid = 1'b0;
        io.add_vld = 1'b0;
        checks++;
        if (budget >= 100) begin
            errors++;
            $display("FAIL credit_fill: responses=%0d required %0d within budget", exp_q.size(), RSP_DEPTH);
        end
        tick();
        checks++;
        if (io.core_req !== 1'b0 || io.outstanding !== 4'd0 || io.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL credit_block: req=%b outstanding=%0d ready=%b required 0 0 1",
                     io.core_req, io.outstanding, io.cmd_ready);
        end
        checks++;
        if (io.rsp_valid !== 1'b1 || {io.rsp_op, io.rsp_data} !== exp_q[0]) begin
            errors++;
            $display("FAIL credit_head: valid=%b rsp=%h required 1 %h", io.rsp_valid,
                     {io.rsp_op, io.rsp_data}, exp_q[0]);
        end
        io.rsp_ready = 1'b1;
        tick();
        io.rsp_ready = 1'b0;
        io.core_accept = 1'b0;
        checks++;
        if (io.core_req !== 1'b1 || {io.core_op, io.core_k, io.core_j, io.core_i} !== cmd_q[0]) begin
            errors++;
            $display("FAIL credit_resume: req=%b cmd=%h required 1 %h", io.core_req,
                     {io.core_op, io.core_k, io.core_j, io.core_i}, cmd_q[0]);
        end
    endtask

    task automatic test_dual();
        do_reset();
        io.core_accept = 1'b1;
        set_cmd({1'b0, 8'd1, 8'd2, 8'd3});
        tick();
        set_cmd({1'b1, 8'd4, 8'd5, 8'd6});
        tick();
        io.cmd_valid = 1'b0;
        tick();
        io.core_accept = 1'b0;
        checks++;
        if (io.outstanding !== 4'd2) begin
            errors++;
            $display("FAIL dual_pre: outstanding=%0d required 2", io.outstanding);
        end
        io.add_vld = 1'b1;
        io.add_data = 8'h11;
        io.mul_vld = 1'b1;
        io.mul_data = 8'h22;
        tick();
        io.add_vld = 1'b0;
        io.mul_vld = 1'b0;
        checks++;
        if (io.rsp_valid !== 1'b1 || io.rsp_data !== 8'h11 || io.rsp_op !== 1'b0 || io.outstanding !== 4'd0
            || io.err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL dual_first: valid=%b data=%h op=%b outstanding=%0d err=%b required 1 11 0 0 0",
                     io.rsp_valid, io.rsp_data, io.rsp_op, io.outstanding, io.err_unexp);
        end
        io.rsp_ready = 1'b1;
        tick();
        io.rsp_ready = 1'b0;
        checks++;
        if (io.rsp_valid !== 1'b1 || io.rsp_data !== 8'h22 || io.rsp_op !== 1'b1) begin
            errors++;
            $display("FAIL dual_second: valid=%b data=%h op=%b required 1 22 1",
                     io.rsp_valid, io.rsp_data, io.rsp_op);
        end
    endtask

    task automatic test_unexp();
        do_reset();
        io.mul_vld = 1'b1;
        io.mul_data = 8'h5C;
        tick();
        io.mul_vld = 1'b0;
        tick();
        tick();
        checks++;
        if (io.err_unexp !== 1'b1 || io.outstanding !== 4'd0) begin
            errors++;
            $display("FAIL unexp_flag: err=%b outstanding=%0d required 1 0", io.err_unexp, io.outstanding);
        end
        checks++;
        if (io.rsp_valid !== 1'b1 || io.rsp_data !== 8'h5C || io.rsp_op !== 1'b1) begin
            errors++;
            $display("FAIL unexp_write: valid=%b data=%h op=%b required 1 5c 1",
                     io.rsp_valid, io.rsp_data, io.rsp_op);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (io.err_unexp !== 1'b0 || io.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL unexp_clear: err=%b rsp_valid=%b required 0 0", io.err_unexp, io.rsp_valid);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            set_cmd(25'($urandom));
            tick();
        end
        io.cmd_valid = 1'b0;
        io.core_accept = 1'b1;
        tick();
        tick();
        io.core_accept = 1'b0;
        set_cmd(25'($urandom));
        tick();
        io.cmd_valid = 1'b0;
        checks++;
        if (io.outstanding !== 4'd2 || cmd_q.size() != 3 || io.core_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: outstanding=%0d queued=%0d req=%b required 2 3 1",
                     io.outstanding, cmd_q.size(), io.core_req);
        end
        rst = 1'b1;
        io.add_vld = 1'b1;
        io.add_data = 8'h77;
        tick();
        io.add_vld = 1'b0;
        checks++;
        if (io.core_req !== 1'b0 || io.outstanding !== 4'd0 || io.cmd_ready !== 1'b1 || io.core_op !== 1'b1
            || io.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_post: req=%b outstanding=%0d ready=%b op=%b rsp_valid=%b required 0 0 1 1 0",
                     io.core_req, io.outstanding, io.cmd_ready, io.core_op, io.rsp_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int ai, mi;
        bit drained;
        pend_t p;
        do_reset();
        pend_q.delete();
        drained = 1'b0;
        for (int cyc = 0; cyc < 700 && !drained; cyc++) begin
            if (cyc < 500 && $urandom_range(0, 1) == 1) set_cmd(25'($urandom));
            else io.cmd_valid = 1'b0;
            io.core_accept = ($urandom_range(0, 3) != 0);
            io.rsp_ready = (cyc >= 500) || ($urandom_range(0, 2) != 0);
            ai = -1;
            mi = -1;
            for (int q = 0; q < pend_q.size(); q++) begin
                if (pend_q[q].due <= cyc) begin
                    if (!pend_q[q].op && ai < 0) ai = q;
                    else if (pend_q[q].op && mi < 0) mi = q;
                end
            end
            io.add_vld = (ai >= 0);
            io.add_data = (ai >= 0) ? pend_q[ai].data : 8'd0;
            io.mul_vld = (mi >= 0);
            io.mul_data = (mi >= 0) ? pend_q[mi].data : 8'd0;
            if (ai > mi) begin
                pend_q.delete(ai);
                if (mi >= 0) pend_q.delete(mi);
            end else begin
                if (mi >= 0) pend_q.delete(mi);
                if (ai >= 0) pend_q.delete(ai);
            end
            tick();
            if (m_issued) begin
                p.op = m_issued_cmd[24];
                p.data = p.op ? 8'(m_issued_cmd[7:0] * m_issued_cmd[15:8] * m_issued_cmd[23:16])
                              : 8'(m_issued_cmd[7:0] + m_issued_cmd[15:8] + m_issued_cmd[23:16]);
                p.due = cyc + 1 + int'($urandom_range(0, 4));
                pend_q.push_back(p);
            end
            checks++;
            if (io.cmd_ready !== e_ready() || io.core_req !== e_req()
                || {io.core_op, io.core_k, io.core_j, io.core_i} !== e_core()) begin
                errors++;
                $display("FAIL rand_cmd: cyc=%0d ready=%b req=%b core=%h required %b %b %h", cyc,
                         io.cmd_ready, io.core_req, {io.core_op, io.core_k, io.core_j, io.core_i},
                         e_ready(), e_req(), e_core());
            end
            checks++;
            if (io.rsp_valid !== (exp_q.size() > 0)
                || (exp_q.size() > 0 && {io.rsp_op, io.rsp_data} !== exp_q[0])) begin
                errors++;
                $display("FAIL rand_rsp: cyc=%0d valid=%b rsp=%h required %b %h", cyc, io.rsp_valid,
                         {io.rsp_op, io.rsp_data}, exp_q.size() > 0, (exp_q.size() > 0) ? exp_q[0] : 9'h0);
            end
            checks++;
            if (io.outstanding !== 4'(m_outst) || io.err_unexp !== m_err) begin
                errors++;
                $display("FAIL rand_cnt: cyc=%0d outstanding=%0d err=%b required %0d %b", cyc,
                         io.outstanding, io.err_unexp, m_outst, m_err);
            end
            if (cyc >= 500 && cmd_q.size() == 0 && exp_q.size() == 0 && m_outst == 0 && pend_q.size() == 0)
                drained = 1'b1;
        end
        idle_inputs();
        checks++;
        if (!drained || io.rsp_valid !== 1'b0 || io.outstanding !== 4'd0 || io.err_unexp !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain: drained=%b rsp_valid=%b outstanding=%0d err=%b required 1 0 0 0",
                     drained, io.rsp_valid, io.outstanding, io.err_unexp);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_credit();
        test_dual();
        test_unexp();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
